matrix_stream_tx: RTL and testbench



---
 rtl/matrix_stream_tx_pkg.sv | 18 +
 rtl/axis_out_reg.sv | 43 ++++
 rtl/matrix_stream_tx.sv | 140 ++++++++++++++
 tb/tb_matrix_stream_tx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_tx_pkg.sv
// Shared definitions for the matrix/vector AXIS stream: FSM encoding, header geometry
// and lane slicing used by both the transmit end and the processing block.
package matrix_stream_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_VEC  = 2'd2
  } state_e;

  localparam int MAT_ELEMS = 12;
  localparam int HDR_BEATS = 3;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXIS output register: load a beat, hold it under backpressure,
// drop valid on handshake. Loading while draining keeps full throughput.
module axis_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_tready,
  output logic             o_tvalid,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_can_load
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  assign o_can_load = !r_valid || i_tready;
  assign o_tvalid   = r_valid;
  assign o_tdata    = r_data;
  assign o_tlast    = r_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_stream_tx.sv
// Matrix/vector AXIS transmitter: three coefficient header beats followed by
// num_vec forwarded upstream vector beats, tlast on the final vector.
module matrix_stream_tx
  import matrix_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_we,
  input  logic [3:0]                  cfg_addr,
  input  logic [DATA_WIDTH-1:0]       cfg_wdata,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        num_vec,
  output logic                        busy,
  output logic                        done,
  input  logic [LANES*DATA_WIDTH-1:0] v_tdata,
  input  logic                        v_tvalid,
  output logic                        v_tready,
  output logic [LANES*DATA_WIDTH-1:0] m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast
);

  localparam logic [1:0]           LAST_HDR = 2'(HDR_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_e                      r_state, w_next;
  logic [1:0]                  r_hdr_idx;
  logic [CNT_WIDTH-1:0]        r_num;
  logic [CNT_WIDTH-1:0]        r_acc;
  logic                        r_done;
  logic [DATA_WIDTH-1:0]       r_mat [MAT_ELEMS];

  logic                        w_start_ok, w_cfg_ok, w_m_hs, w_v_hs, w_can_load;
  logic                        w_load, w_load_last, w_v_ready;
  logic [1:0]                  w_hdr_sel;
  logic [LANES*DATA_WIDTH-1:0] w_hdr_data, w_load_data;

  assign w_start_ok  = start && (num_vec != '0);
  assign w_cfg_ok    = cfg_we && (r_state == ST_IDLE) && (cfg_addr < 4'(MAT_ELEMS));
  assign w_m_hs      = m_tvalid && m_tready;
  assign w_v_hs      = w_v_ready && v_tvalid;
  assign w_hdr_sel   = (r_state == ST_HDR) ? r_hdr_idx + 2'd1 : 2'd0;
  assign w_load_data = (r_state == ST_VEC) ? v_tdata : w_hdr_data;

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign v_tready = w_v_ready;

  // Header beat k, lane j carries coefficient 4k+j (row-major).
  always_comb begin
    w_hdr_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (int'(w_hdr_sel) * LANES + j < MAT_ELEMS)
        w_hdr_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = r_mat[4'(int'(w_hdr_sel) * LANES + j)];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_v_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next = ST_HDR;
          w_load = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_m_hs) begin
          if (r_hdr_idx == LAST_HDR) w_next = ST_VEC;
          else                       w_load = 1'b1;
        end
      end
      ST_VEC: begin
        w_v_ready = (r_acc != r_num) && w_can_load;
        if (w_v_ready && v_tvalid) begin
          w_load      = 1'b1;
          w_load_last = (r_acc == r_num - ONE);
        end
        if (w_m_hs && m_tlast) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: the coefficient store is reset explicitly because a mid-frame reset
  // must leave a clean all-zero matrix, not stale values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hdr_idx <= '0;
      r_num     <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i < MAT_ELEMS; i++) r_mat[i] <= '0;
    end else begin
      r_done <= (r_state == ST_VEC) && w_m_hs && m_tlast;
      if (w_cfg_ok) r_mat[cfg_addr] <= cfg_wdata;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_num     <= num_vec;
            r_acc     <= '0;
            r_hdr_idx <= '0;
          end
        end
        ST_HDR: if (w_m_hs && r_hdr_idx != LAST_HDR) r_hdr_idx <= r_hdr_idx + 2'd1;
        ST_VEC: if (w_v_hs) r_acc <= r_acc + ONE;
        default: ;
      endcase
    end
  end

  axis_out_reg #(.WIDTH(LANES*DATA_WIDTH)) u_out (
    .clk        (aclk),
    .rst_n      (aresetn),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_last     (w_load_last),
    .i_tready   (m_tready),
    .o_tvalid   (m_tvalid),
    .o_tdata    (m_tdata),
    .o_tlast    (m_tlast),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: header content, timing, backpressure,
// upstream gaps, ignored commands, mid-frame reset and a full-length frame.
module tb_matrix_stream_tx;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int CW = 16;
  localparam int BW = DW * LN;

  localparam logic [BW-1:0] H0 = 64'h0004_0003_0002_0001;
  localparam logic [BW-1:0] H1 = 64'h0008_0007_0006_0005;
  localparam logic [BW-1:0] H2 = 64'h000C_000B_000A_0009;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          busy, done;
  logic [BW-1:0] v_tdata = '0;
  logic          v_tvalid = 1'b0;
  logic          v_tready;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;

  always #5 aclk = ~aclk;

  matrix_stream_tx #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .v_tdata(v_tdata), .v_tvalid(v_tvalid), .v_tready(v_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [BW-1:0] beat_q[$];
  bit            last_q[$];
  int            bcyc_q[$];
  int            done_q[$];
  bit            done_busy_q[$];
  logic [BW-1:0] vec_q[$];

  bit            track_busy = 1'b0;
  int            busy_drops = 0;
  int            stall_errs = 0;
  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(posedge aclk) cyc++;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) stall_errs++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (m_tvalid && m_tready) begin
        beat_q.push_back(m_tdata);
        last_q.push_back(m_tlast);
        bcyc_q.push_back(cyc);
      end
      if (done) begin
        done_q.push_back(cyc);
        done_busy_q.push_back(busy);
        track_busy = 1'b0;
      end else if (track_busy && !busy) begin
        busy_drops++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_log();
    beat_q.delete();
    last_q.delete();
    bcyc_q.delete();
    done_q.delete();
    done_busy_q.delete();
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [DW-1:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [CW-1:0] nv, output int t);
    start = 1'b1;
    num_vec = nv;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vecs(input int gap);
    int n;
    while (vec_q.size() > 0) begin
      v_tdata = vec_q.pop_front();
      v_tvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!v_tready && n < 500) begin
        @(negedge aclk);
        n++;
      end
      if (!v_tready) begin
        checks++;
        failures++;
        $display("FAIL send_vecs_timeout v_tready stayed 0 for %0d cycles, required 1", n);
        v_tvalid = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
      v_tvalid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_q.size() == 0 && n < bound) begin
      @(posedge aclk);
      n++;
    end
    #1;
    checks++;
    if (done_q.size() == 0) begin
      failures++;
      $display("FAIL wait_done no done pulse within %0d cycles, required one", bound);
    end
  endtask

  task automatic check_beats(input string tag, input logic [BW-1:0] exp[], input int last_idx);
    logic [BW-1:0] got;
    bit            gl;
    checks++;
    if (beat_q.size() !== exp.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", tag, beat_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : 'x;
      gl  = (i < last_q.size()) ? last_q[i] : !(i == last_idx);
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL %s_data[%0d] got=%h exp=%h", tag, i, got, exp[i]);
      end
      checks++;
      if (gl !== (i == last_idx)) begin
        failures++;
        $display("FAIL %s_tlast[%0d] got=%0b exp=%0b", tag, i, gl, (i == last_idx));
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({m_tvalid, m_tlast, v_tready, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got={valid,last,vready,busy,done}=%b exp=00000",
               {m_tvalid, m_tlast, v_tready, busy, done});
    end
    checks++;
    if (m_tdata !== '0) begin
      failures++;
      $display("FAIL reset_tdata got=%h exp=0", m_tdata);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t;
    int exp_cyc[5];
    logic [BW-1:0] exp[] = '{H0, H1, H2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
    for (int i = 0; i < 12; i++) cfg_write(4'(i), DW'(i + 1));
    clear_log();
    m_tready = 1'b1;
    vec_q = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
    do_start(16'd2, t);
    fork
      send_vecs(0);
      wait_done(100);
    join
    check_beats("basic", exp, 4);
    exp_cyc = '{t + 1, t + 2, t + 3, t + 5, t + 6};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= bcyc_q.size() || bcyc_q[i] !== exp_cyc[i]) begin
        failures++;
        $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i,
                 (i < bcyc_q.size()) ? bcyc_q[i] : -1, exp_cyc[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== t + 7) begin
      failures++;
      $display("FAIL basic_done_cycle got=%0d exp=%0d", (done_q.size() > 0) ? done_q[0] : -1, t + 7);
    end
    checks++;
    if (done_busy_q.size() != 1 || done_busy_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_at_done got=%0b exp=0", (done_busy_q.size() > 0) ? done_busy_q[0] : 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic [BW-1:0] exp[] = '{H0, H1, H2, 64'h1111, 64'h2222, 64'h3333, 64'h4444};
    clear_log();
    stall_errs = 0;
    m_tready = 1'b0;
    vec_q = '{64'h1111, 64'h2222, 64'h3333, 64'h4444};
    do_start(16'd4, t);
    fork
      send_vecs(0);
      begin
        int n = 0;
        while (done_q.size() == 0 && n < 300) begin
          tick();
          m_tready = ~m_tready;
          n++;
        end
      end
      wait_done(300);
    join
    m_tready = 1'b1;
    check_beats("bp", exp, 6);
    checks++;
    if (stall_errs !== 0) begin
      failures++;
      $display("FAIL bp_stall_stability got=%0d violations exp=0", stall_errs);
    end
    checks++;
    if (done_q.size() !== 1) begin
      failures++;
      $display("FAIL bp_done_count got=%0d exp=1", done_q.size());
    end
  endtask

  task automatic test_gaps();
    int t;
    logic [BW-1:0] exp[] = '{H0, H1, H2, 64'hA, 64'hB, 64'hC};
    clear_log();
    m_tready = 1'b1;
    vec_q = '{64'hA, 64'hB, 64'hC};
    do_start(16'd3, t);
    busy_drops = 0;
    track_busy = 1'b1;
    fork
      send_vecs(3);
      wait_done(200);
    join
    check_beats("gaps", exp, 5);
    for (int i = 4; i < 6; i++) begin
      checks++;
      if (i >= bcyc_q.size() || bcyc_q[i] - bcyc_q[i-1] !== 4) begin
        failures++;
        $display("FAIL gaps_spacing[%0d] got=%0d exp=4", i,
                 (i < bcyc_q.size()) ? bcyc_q[i] - bcyc_q[i-1] : -1);
      end
    end
    checks++;
    if (busy_drops !== 0) begin
      failures++;
      $display("FAIL gaps_busy got=%0d cycles low exp=0", busy_drops);
    end
    track_busy = 1'b0;
  endtask

  task automatic test_ignored();
    int t;
    logic [BW-1:0] exp[] = '{H0, H1, H2, 64'h99};
    clear_log();
    cfg_write(4'd15, 16'hBEEF);
    do_start(16'd0, t);
    repeat (5) tick();
    checks++;
    if (beat_q.size() !== 0 || done_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_zero_start got beats=%0d dones=%0d busy=%0b exp 0/0/0",
               beat_q.size(), done_q.size(), busy);
    end
    m_tready = 1'b0;
    vec_q = '{64'h99};
    do_start(16'd1, t);
    start = 1'b1;
    num_vec = 16'd5;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_wdata = 16'hFFFF;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ign_busy got=%0b exp=1", busy);
    end
    m_tready = 1'b1;
    fork
      send_vecs(0);
      wait_done(100);
    join
    repeat (20) tick();
    check_beats("ign", exp, 3);
    checks++;
    if (done_q.size() !== 1) begin
      failures++;
      $display("FAIL ign_done_count got=%0d exp=1", done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [BW-1:0] exp[] = '{64'h0, 64'h0, 64'h0, 64'h77};
    clear_log();
    m_tready = 1'b1;
    do_start(16'd2, t);
    tick();
    tick();
    checks++;
    if (beat_q.size() !== 2) begin
      failures++;
      $display("FAIL rmid_pre_beats got=%0d exp=2", beat_q.size());
    end
    aresetn = 1'b0;
    tick();
    checks++;
    if ({m_tvalid, m_tlast, v_tready, busy, done} !== 5'b0 || m_tdata !== '0) begin
      failures++;
      $display("FAIL rmid_outputs got ctrl=%b tdata=%h exp 00000/0",
               {m_tvalid, m_tlast, v_tready, busy, done}, m_tdata);
    end
    aresetn = 1'b1;
    tick();
    clear_log();
    vec_q = '{64'h77};
    do_start(16'd1, t);
    fork
      send_vecs(0);
      wait_done(100);
    join
    check_beats("rmid", exp, 3);
  endtask

  task automatic test_long();
    int t;
    int lasts = 0;
    clear_log();
    m_tready = 1'b1;
    v_tdata = 64'h1234_5678_9ABC_DEF0;
    v_tvalid = 1'b1;
    do_start(16'hFFFF, t);
    wait_done(70000);
    v_tvalid = 1'b0;
    repeat (5) tick();
    checks++;
    if (beat_q.size() !== 65538) begin
      failures++;
      $display("FAIL long_count got=%0d exp=65538", beat_q.size());
    end
    foreach (last_q[i]) if (last_q[i]) lasts++;
    checks++;
    if (lasts !== 1 || last_q.size() == 0 || last_q[last_q.size()-1] !== 1'b1) begin
      failures++;
      $display("FAIL long_tlast got=%0d lasts exp=1 on final beat", lasts);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== t + 65540) begin
      failures++;
      $display("FAIL long_done_cycle got=%0d exp=%0d", (done_q.size() > 0) ? done_q[0] : -1, t + 65540);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_ignored();
    test_reset_mid();
    for (int i = 0; i < 12; i++) cfg_write(4'(i), DW'(i + 1));
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
